// File: rtl/connect_four_pkg.sv
// Shared connect-four encodings, AI level/reason codes and the win detector
// used by the AI move picker.
package connect_four_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    typedef enum logic [1:0] {
        LVL_RANDOM    = 2'd0,
        LVL_WIN       = 2'd1,
        LVL_WIN_BLOCK = 2'd2,
        LVL_RSVD      = 2'd3
    } ai_level_t;

    localparam logic [1:0] REASON_RANDOM = 2'b00;
    localparam logic [1:0] REASON_WIN    = 2'b01;
    localparam logic [1:0] REASON_BLOCK  = 2'b10;

    localparam logic [9:0] LFSR_SEED = 10'b1010101010;

    // Boards up to 16x16 are padded into this shape so one function serves every size.
    localparam int MAX_ROWS = 16;
    localparam int MAX_COLS = 16;
    typedef logic [1:0] board_max_t [MAX_ROWS][MAX_COLS];

    // True when dropping piece p at (r, c) yields four in a row through that cell.
    function automatic logic wins_at(input board_max_t b,
                                     input int         rows,
                                     input int         cols,
                                     input int         r,
                                     input int         c,
                                     input logic [1:0] p);
        logic       hit;
        logic [6:0] m;
        int         dr;
        int         dc;
        int         rr;
        int         cc;
        hit = 1'b0;
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            for (int k = 0; k < 7; k++) begin
                rr = r + (k - 3) * dr;
                cc = c + (k - 3) * dc;
                if (k == 3)
                    m[k] = 1'b1;
                else if (rr >= 0 && rr < rows && cc >= 0 && cc < cols)
                    m[k] = (b[rr[3:0]][cc[3:0]] == p);
                else
                    m[k] = 1'b0;
            end
            for (int s = 0; s < 4; s++)
                if (&m[s +: 4]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/connect_four_ai_l2_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1) supplying the scan start offset.
module connect_four_ai_l2_lfsr
    import connect_four_pkg::*;
#(
    parameter int OUT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/connect_four_ai_l2.sv
// Connect-four AI move picker: scans one column per cycle from a random offset
// and chooses win > block > first legal column according to the requested level.
module connect_four_ai_l2
    import connect_four_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 8,
    parameter int CW   = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ai_start,
    input  logic [1:0]    level,
    input  logic [1:0]    ai_piece,
    input  logic [1:0]    board [ROWS][COLS],
    output logic [CW-1:0] ai_col,
    output logic          ai_done,
    output logic          ai_full,
    output logic [1:0]    ai_reason
);

    // state  | meaning
    // IDLE   | waiting for ai_start
    // SCAN   | evaluate one column per cycle, record first hits one cycle later
    // DECIDE | apply level priority to the recorded hits
    // DONE   | result presented until ai_start falls
    typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;

    state_t        state_q, state_d;
    ai_level_t     lvl_q, lvl_d;
    logic [CW-1:0] lfsr_off;
    logic [CW-1:0] off_q, off_d;
    logic [CW:0]   k_q, k_d;

    logic          ev_vld_q, ev_vld_d;
    logic [CW-1:0] ev_col_q, ev_col_d;
    logic          ev_legal_q, ev_legal_d;
    logic          ev_win_q, ev_win_d;
    logic          ev_blk_q, ev_blk_d;

    logic          has_legal_q, has_legal_d;
    logic          has_win_q, has_win_d;
    logic          has_blk_q, has_blk_d;
    logic [CW-1:0] first_legal_q, first_legal_d;
    logic [CW-1:0] first_win_q, first_win_d;
    logic [CW-1:0] first_blk_q, first_blk_d;

    logic [CW-1:0] ai_col_q, ai_col_d;
    logic          ai_done_q, ai_done_d;
    logic          ai_full_q, ai_full_d;
    logic [1:0]    ai_reason_q, ai_reason_d;

    board_max_t    bm;
    logic [CW-1:0] scan_col;
    logic [1:0]    opp_piece;
    logic          col_legal;
    logic          col_win_ai;
    logic          col_win_opp;
    int            land_row;

    connect_four_ai_l2_lfsr #(.OUT_W(CW)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr_off)
    );

    always_comb begin
        for (int r = 0; r < MAX_ROWS; r++)
            for (int c = 0; c < MAX_COLS; c++)
                bm[r][c] = EMPTY;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                bm[r][c] = board[r][c];
    end

    // COLS is a power of two, so the CW-bit add wraps modulo COLS.
    assign scan_col  = off_q + k_q[CW-1:0];
    assign opp_piece = (ai_piece == P1) ? P2 : P1;

    always_comb begin
        land_row = 0;
        for (int r = 0; r < ROWS; r++)
            if (board[r][scan_col] == EMPTY) land_row = r;
        col_legal   = (board[0][scan_col] == EMPTY);
        col_win_ai  = col_legal && wins_at(bm, ROWS, COLS, land_row, int'(scan_col), ai_piece);
        col_win_opp = col_legal && wins_at(bm, ROWS, COLS, land_row, int'(scan_col), opp_piece);
    end

    always_comb begin
        state_d       = state_q;
        lvl_d         = lvl_q;
        off_d         = off_q;
        k_d           = k_q;
        ev_vld_d      = 1'b0;
        ev_col_d      = ev_col_q;
        ev_legal_d    = ev_legal_q;
        ev_win_d      = ev_win_q;
        ev_blk_d      = ev_blk_q;
        has_legal_d   = has_legal_q;
        has_win_d     = has_win_q;
        has_blk_d     = has_blk_q;
        first_legal_d = first_legal_q;
        first_win_d   = first_win_q;
        first_blk_d   = first_blk_q;
        ai_col_d      = ai_col_q;
        ai_done_d     = ai_done_q;
        ai_full_d     = ai_full_q;
        ai_reason_d   = ai_reason_q;

        case (state_q)
            IDLE: begin
                if (ai_start) begin
                    state_d       = SCAN;
                    off_d         = lfsr_off;
                    lvl_d         = ai_level_t'(level);
                    k_d           = '0;
                    has_legal_d   = 1'b0;
                    has_win_d     = 1'b0;
                    has_blk_d     = 1'b0;
                    first_legal_d = '0;
                    first_win_d   = '0;
                    first_blk_d   = '0;
                end
            end
            SCAN: begin
                if (!ai_start) begin
                    state_d = IDLE;
                end else begin
                    if (ev_vld_q) begin
                        if (ev_legal_q && !has_legal_q) begin
                            has_legal_d   = 1'b1;
                            first_legal_d = ev_col_q;
                        end
                        if (ev_win_q && !has_win_q) begin
                            has_win_d   = 1'b1;
                            first_win_d = ev_col_q;
                        end
                        if (ev_blk_q && !has_blk_q) begin
                            has_blk_d   = 1'b1;
                            first_blk_d = ev_col_q;
                        end
                    end
                    // One extra cycle after the last column drains the evaluation register.
                    if (!k_q[CW]) begin
                        ev_vld_d   = 1'b1;
                        ev_col_d   = scan_col;
                        ev_legal_d = col_legal;
                        ev_win_d   = col_win_ai;
                        ev_blk_d   = col_win_opp;
                        k_d        = k_q + 1'b1;
                    end else begin
                        state_d = DECIDE;
                    end
                end
            end
            DECIDE: begin
                if (!ai_start) begin
                    state_d = IDLE;
                end else begin
                    state_d     = DONE;
                    ai_done_d   = 1'b1;
                    ai_full_d   = 1'b0;
                    ai_reason_d = REASON_RANDOM;
                    if (has_win_q && lvl_q != LVL_RANDOM) begin
                        ai_col_d    = first_win_q;
                        ai_reason_d = REASON_WIN;
                    end else if (has_blk_q && (lvl_q == LVL_WIN_BLOCK || lvl_q == LVL_RSVD)) begin
                        ai_col_d    = first_blk_q;
                        ai_reason_d = REASON_BLOCK;
                    end else if (has_legal_q) begin
                        ai_col_d = first_legal_q;
                    end else begin
                        ai_col_d  = off_q;
                        ai_full_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!ai_start) begin
                    state_d   = IDLE;
                    ai_done_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lvl_q         <= LVL_RANDOM;
            off_q         <= '0;
            k_q           <= '0;
            ev_vld_q      <= 1'b0;
            ev_col_q      <= '0;
            ev_legal_q    <= 1'b0;
            ev_win_q      <= 1'b0;
            ev_blk_q      <= 1'b0;
            has_legal_q   <= 1'b0;
            has_win_q     <= 1'b0;
            has_blk_q     <= 1'b0;
            first_legal_q <= '0;
            first_win_q   <= '0;
            first_blk_q   <= '0;
            ai_col_q      <= '0;
            ai_done_q     <= 1'b0;
            ai_full_q     <= 1'b0;
            ai_reason_q   <= REASON_RANDOM;
        end else begin
            state_q       <= state_d;
            lvl_q         <= lvl_d;
            off_q         <= off_d;
            k_q           <= k_d;
            ev_vld_q      <= ev_vld_d;
            ev_col_q      <= ev_col_d;
            ev_legal_q    <= ev_legal_d;
            ev_win_q      <= ev_win_d;
            ev_blk_q      <= ev_blk_d;
            has_legal_q   <= has_legal_d;
            has_win_q     <= has_win_d;
            has_blk_q     <= has_blk_d;
            first_legal_q <= first_legal_d;
            first_win_q   <= first_win_d;
            first_blk_q   <= first_blk_d;
            ai_col_q      <= ai_col_d;
            ai_done_q     <= ai_done_d;
            ai_full_q     <= ai_full_d;
            ai_reason_q   <= ai_reason_d;
        end
    end

    assign ai_col    = ai_col_q;
    assign ai_done   = ai_done_q;
    assign ai_full   = ai_full_q;
    assign ai_reason = ai_reason_q;

endmodule

// File: tb/tb_connect_four_ai_l2.sv
// Scoreboard bench for connect_four_ai_l2: directed boards push expected moves,
// a monitor pops and compares whenever ai_done rises.
module tb_connect_four_ai_l2;
    import connect_four_pkg::*;

    localparam int ROWS = 6;
    localparam int COLS = 8;
    localparam int CW   = 3;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          ai_start = 1'b0;
    logic [1:0]    level    = 2'd0;
    logic [1:0]    ai_piece = P1;
    logic [1:0]    board [ROWS][COLS];
    logic [CW-1:0] ai_col;
    logic          ai_done;
    logic          ai_full;
    logic [1:0]    ai_reason;

    typedef struct {
        string name;
        int    col;
        int    reason;
        int    full;
        int    done_cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks    = 0;
    int         passes    = 0;
    int         cyc       = 0;
    int         last_col  = 0;
    logic       done_prev = 1'b0;
    logic [9:0] lfsr_m;

    connect_four_ai_l2 #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ai_start  (ai_start),
        .level     (level),
        .ai_piece  (ai_piece),
        .board     (board),
        .ai_col    (ai_col),
        .ai_done   (ai_done),
        .ai_full   (ai_full),
        .ai_reason (ai_reason)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^10 + x^7 + 1, seed 1010101010, advancing every cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 10'b1010101010;
        else       lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int first_of_3_7(input int off);
        int c;
        for (int k = 0; k < COLS; k++) begin
            c = (off + k) % COLS;
            if (c == 3 || c == 7) return c;
        end
        return -1;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board[r][c] = EMPTY;
    endtask

    task automatic fill_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board[r][c] = (((r + c) % 2) == 0) ? P1 : P2;
    endtask

    // exp_col: >=0 fixed column, -1 = start offset, -2 = first of {3,7} from offset.
    task automatic do_search(input string name, input logic [1:0] lvl, input int exp_col,
                             input int exp_reason, input int exp_full, input int hold);
        exp_t e;
        int   off;
        int   n;
        @(negedge clk);
        level    = lvl;
        ai_start = 1'b1;
        off      = int'(lfsr_m[CW-1:0]);
        e.name   = name;
        e.col    = (exp_col == -1) ? off : ((exp_col == -2) ? first_of_3_7(off) : exp_col);
        e.reason = exp_reason;
        e.full   = exp_full;
        e.done_cyc = cyc + 1 + COLS + 2;
        sb.push_back(e);
        n = 0;
        while (ai_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_done"}, int'(ai_done), 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #2;
            check({name, "_hold_done"}, int'(ai_done), 1);
            check({name, "_hold_col"}, int'(ai_col), e.col);
        end
        @(negedge clk);
        ai_start = 1'b0;
        @(posedge clk);
        #2;
        check({name, "_done_clear"}, int'(ai_done), 0);
        last_col = e.col;
    endtask

    always @(posedge clk) begin
        #1;
        if (ai_done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", int'(ai_done), 0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_col"}, int'(ai_col), mon_e.col);
                check({mon_e.name, "_reason"}, int'(ai_reason), mon_e.reason);
                check({mon_e.name, "_full"}, int'(ai_full), mon_e.full);
                check({mon_e.name, "_latency"}, cyc, mon_e.done_cyc);
            end
        end
        done_prev = ai_done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_board();
        repeat (3) @(negedge clk);
        check("rst_col", int'(ai_col), 0);
        check("rst_done", int'(ai_done), 0);
        check("rst_full", int'(ai_full), 0);
        check("rst_reason", int'(ai_reason), 0);
        reset = 1'b0;

        do_search("empty_random", 2'd0, -1, 0, 0, 0);

        clear_board();
        board[5][2] = P1; board[4][2] = P1; board[3][2] = P1;
        do_search("vert_win", 2'd1, 2, 1, 0, 0);

        clear_board();
        board[5][4] = P2; board[5][5] = P2; board[5][6] = P2;
        do_search("block", 2'd2, -2, 2, 0, 0);
        do_search("block_lvl_win", 2'd1, -1, 0, 0, 0);
        do_search("block_lvl3", 2'd3, -2, 2, 0, 0);

        clear_board();
        ai_piece = P2;
        board[5][4] = P1; board[5][5] = P1; board[5][6] = P1;
        do_search("block_p2", 2'd2, -2, 2, 0, 0);
        ai_piece = P1;

        clear_board();
        board[5][2] = P1; board[4][2] = P1; board[3][2] = P1;
        board[5][4] = P2; board[5][5] = P2; board[5][6] = P2;
        do_search("win_over_block", 2'd2, 2, 1, 0, 0);

        clear_board();
        board[5][0] = P1;
        board[5][1] = P2; board[4][1] = P1;
        board[5][2] = P2; board[4][2] = P2; board[3][2] = P1;
        board[5][3] = P2; board[4][3] = P2; board[3][3] = P2;
        do_search("diag_win", 2'd1, 3, 1, 0, 0);

        fill_board();
        for (int r = 0; r < ROWS; r++) board[r][6] = EMPTY;
        do_search("only_col6", 2'd0, 6, 0, 0, 20);

        fill_board();
        do_search("full_board", 2'd2, -1, 0, 1, 0);

        // Abort in the third SCAN cycle: no result, previous column kept.
        clear_board();
        @(negedge clk);
        level    = 2'd0;
        ai_start = 1'b1;
        repeat (3) @(negedge clk);
        ai_start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("abort_done", int'(ai_done), 0);
        check("abort_col", int'(ai_col), last_col);
        check("abort_full_kept", int'(ai_full), 1);

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        ai_start = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_col", int'(ai_col), 0);
        check("midrst_done", int'(ai_done), 0);
        check("midrst_full", int'(ai_full), 0);
        check("midrst_reason", int'(ai_reason), 0);
        ai_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_search("post_reset", 2'd0, -1, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/connect_four_ai_l2.md
CONNECT_FOUR_AI_L2 -- requirements
Module: connect_four_ai_l2

Interface
REQ-001 SHALL have parameter ROWS, default 6, meaning board rows (row 0 = top).
REQ-002 SHALL have parameter COLS, default 8, meaning board columns; a power of two, 4..16.
REQ-003 SHALL have parameter CW, default $clog2(COLS), meaning column-index width.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ai_start  input  1  level request; high while the controller waits for an AI move.
REQ-007 SHALL have port level  input  2  ai_level_t: RANDOM=0, WIN=1, WIN_BLOCK=2; 3 behaves as WIN_BLOCK.
REQ-008 SHALL have port ai_piece  input  2  encoding of the AI's pieces; the opponent's encoding is the other non-EMPTY value.
REQ-009 SHALL have port board  input  2 x [ROWS][COLS]  board state; EMPTY=2'b00.
REQ-010 SHALL have port ai_col  output  CW  chosen column.
REQ-011 SHALL have port ai_done  output  1  move ready; held until ai_start falls.
REQ-012 SHALL have port ai_full  output  1  no legal column exists; valid while ai_done=1.
REQ-013 SHALL have port ai_reason  output  2  00 random, 01 win, 10 block; valid while ai_done=1.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DECIDE, DONE.
REQ-015 IDLE->SCAN SHALL occur when ai_start=1, latching start offset off = lfsr[CW-1:0] and level.
REQ-016 SCAN SHALL evaluate one column per cycle, c = (off + k) mod COLS for k = 0..COLS-1, then go to DECIDE.
REQ-017 For column c: legal iff board[0][c]==EMPTY; landing row = largest r with board[r][c]==EMPTY.
REQ-018 For a legal c, the block SHALL compute win_ai and win_opp: placing the respective piece at (landing row, c) completes >=4 contiguous in horizontal, vertical, or either diagonal, with out-of-board cells counting as non-matching.
REQ-019 The block SHALL record the first legal, first win_ai, and first win_opp column in scan order; later hits SHALL NOT overwrite them.
REQ-020 DECIDE SHALL select ai_col by priority: first win_ai if level!=RANDOM, else first win_opp if level>=WIN_BLOCK, else first legal column; it SHALL set ai_reason accordingly.
REQ-021 With no legal column, DECIDE SHALL set ai_col=off, ai_full=1, ai_reason=00.
REQ-022 DECIDE->DONE SHALL be unconditional; ai_done SHALL rise on the clock edge entering DONE, i.e. exactly COLS+2 cycles after the edge that samples ai_start=1 in IDLE.
REQ-023 In DONE, ai_done, ai_col, ai_full and ai_reason SHALL hold stable while ai_start=1; when ai_start=0, the block SHALL go to IDLE and clear ai_done on that edge.
REQ-024 If ai_start falls during SCAN or DECIDE, the block SHALL abort to IDLE without asserting ai_done; ai_col keeps its previous value.
REQ-025 Board changes during SCAN are a controller error; the result SHALL reflect the value sampled at each column's scan cycle.
REQ-026 ai_start held high after DONE SHALL NOT start a new search; a new search requires a pass through IDLE.
REQ-027 The LFSR SHALL advance every cycle irrespective of state.

Reset
REQ-028 Reset SHALL force state IDLE, ai_col=0, ai_done=0, ai_full=0, ai_reason=00, and all scan records cleared, asynchronously.
REQ-029 Reset asserted mid-SCAN SHALL discard the search; the first post-reset search SHALL start only from IDLE.
REQ-030 The LFSR SHALL load its fixed non-zero seed 10'b1010101010 on reset.

Structure
REQ-031 connect_four_pkg SHALL hold EMPTY/P1/P2 encodings, ai_level_t, and the reason codes.
REQ-032 A single sub-module SHALL be instantiated: the existing 10-bit LFSR.
REQ-033 Win detection SHALL be a combinational function in the package, parameterised on ROWS/COLS.

Verification
REQ-034 Empty 6x8 board, level RANDOM, ai_start=1 -> ai_done=1 after exactly 10 cycles, ai_col=off, ai_reason=00, ai_full=0.
REQ-035 AI has three pieces at rows 5, 4, 3 of column 2; level WIN -> ai_col=2, ai_reason=01.
REQ-036 Opponent has row 5 cols 4,5,6; AI has none threatening; level WIN_BLOCK -> ai_col=3 or 7, whichever comes first from off, ai_reason=10; level WIN on the same board -> ai_reason=00.
REQ-037 Board full except column 6 -> ai_col=6; completely full board -> ai_full=1, ai_col=off.
REQ-038 Drop ai_start on the 3rd SCAN cycle -> ai_done never rises, state returns to IDLE; reset pulse mid-SCAN -> all outputs reach 0 immediately.
REQ-039 Hold ai_start 20 cycles after ai_done -> outputs stable, no rescan; drop ai_start -> ai_done=0 on the next edge.
